// File: rtl/dec_ram_reader.sv
// Read-out engine for the decoded-bit RAM: reads one bank bit by bit and streams
// LSB-first packed words on a valid/ready port, with one staging word for backpressure.
module dec_ram_reader #(
  parameter int A_WIDTH   = 8,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 bank,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_cs,
  output logic                 ram_we,
  output logic                 ram_rs,
  output logic [A_WIDTH-1:0]   ram_addr,
  output logic                 ram_din,
  input  logic                 ram_dout,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int CW = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_MAX  = CW'(OUT_WIDTH - 1);
  localparam logic [A_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t               state;
  logic [CW-1:0]        pack_cnt;
  logic [OUT_WIDTH-1:0] pack;
  logic                 stg_valid;
  logic                 stg_last;
  logic [OUT_WIDTH-1:0] stg_data;

  logic [OUT_WIDTH-1:0] word_new;
  logic [1:0]           occ;
  logic                 word_done;
  logic                 word_last;

  assign ram_we  = 1'b0;
  assign ram_din = 1'b0;

  // A read is captured on the edge closing its cycle; if that bit completes a
  // word it needs a free slot in the output/staging pair after that edge.
  always_comb begin
    word_new           = pack;
    word_new[pack_cnt] = ram_dout;
    occ                = 2'(m_valid & ~m_ready) + 2'(stg_valid);
    ram_cs             = (state == RUN) && ((pack_cnt != CNT_MAX) || (occ != 2'd2));
    word_done          = ram_cs && (pack_cnt == CNT_MAX);
    word_last          = ram_cs && (ram_addr == ADDR_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_rs    <= 1'b0;
      ram_addr  <= '0;
      pack_cnt  <= '0;
      pack      <= '0;
      stg_valid <= 1'b0;
      stg_last  <= 1'b0;
      stg_data  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
    end else begin
      if (ram_cs) begin
        pack     <= word_new;
        pack_cnt <= word_done ? '0 : pack_cnt + 1'b1;
        if (ram_addr != ADDR_MAX) ram_addr <= ram_addr + 1'b1;
      end

      // Staging always feeds the output register first to keep word order.
      if (!m_valid || m_ready) begin
        if (stg_valid) begin
          m_valid   <= 1'b1;
          m_data    <= stg_data;
          m_last    <= stg_last;
          stg_valid <= word_done;
          if (word_done) begin
            stg_data <= word_new;
            stg_last <= word_last;
          end
        end else if (word_done) begin
          m_valid <= 1'b1;
          m_data  <= word_new;
          m_last  <= word_last;
        end else begin
          m_valid <= 1'b0;
          m_last  <= 1'b0;
        end
      end else if (word_done) begin
        stg_valid <= 1'b1;
        stg_data  <= word_new;
        stg_last  <= word_last;
      end

      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          ram_rs   <= bank;
          ram_addr <= '0;
        end
        RUN: if (word_last) state <= DRAIN;
        DRAIN: if (m_valid && m_ready && m_last) begin
          state <= FIN;
          done  <= 1'b1;
        end
        FIN: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          ram_rs <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dec_ram_reader.md
Name: dec_ram_reader

Overview:
- Read-out engine for the decoded-bit RAM (DEC_RAM, 1-bit data, synchronous read).
- After the LDPC decoder writes hard-decision bits into one bank, this block reads that bank sequentially.
- It packs the bits into OUT_WIDTH-bit words and streams them out on a valid/ready interface toward the host/output FIFO.
- It is the read-side master of the DEC_RAM port.

Parameters:
A_WIDTH, 8, RAM address width; the frame holds 2^A_WIDTH bits.
OUT_WIDTH, 8, packed output word width; must divide 2^A_WIDTH (1..2^A_WIDTH).

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to read out a frame; sampled only in IDLE
bank  in  1  bank to read, latched with start
busy  out  1  high from the edge that accepts start until the done pulse (inclusive)
done  out  1  one-cycle pulse after the final word handshake
ram_cs  out  1  RAM chip select, high only in cycles that issue a read
ram_we  out  1  constant 0
ram_rs  out  1  RAM bank select, equals latched bank while busy, 0 otherwise
ram_addr  out  A_WIDTH  read address
ram_din  out  1  constant 0
ram_dout  in  1  RAM read data, valid on the edge after ram_addr/ram_cs are presented
m_data  out  OUT_WIDTH  packed word
m_valid  out  1  m_data valid
m_ready  in  1  downstream accept
m_last  out  1  marks the final word of the frame

Behaviour:
- Reset (async, immediate): all outputs 0, FSM to IDLE, pack/inflight state cleared. Reset mid-frame abandons the frame; no done pulse.
- FSM states:
  - IDLE: start=1 at an edge -> latch bank, addr counter=0, go to RUN.
  - RUN: issue reads. When the last address has been issued and its bit captured, go to DRAIN.
  - DRAIN: wait for the final word handshake, then go to FIN.
  - FIN: done=1 for one cycle, busy=1, then go to IDLE.
- start while not in IDLE is ignored. A start in the FIN cycle is also ignored.
- Read timing: the address for bit k is presented with ram_cs=1 in one cycle. ram_dout is captured at the next rising edge.
- Address order is 0..2^A_WIDTH-1 with no wrap. The counter stops after the last address.
- Packing: bit at address a goes to m_data[a mod OUT_WIDTH], LSB first. Word index = a / OUT_WIDTH.
- Throughput: with m_ready held 1, one read per cycle with no bubbles.
  - First m_valid rises OUT_WIDTH edges after the start-accepting edge (e.g. 8 cycles).
  - Subsequent words follow every OUT_WIDTH cycles.
- Output register:
  - m_valid rises when a word completes.
  - Handshake = m_valid & m_ready at an edge.
  - m_data and m_last are stable while m_valid & !m_ready.
  - m_valid drops after the handshake unless the next word completes on the same edge.
- Backpressure:
  - One staging word beyond the output register is permitted.
  - Reads stall (ram_cs=0, addr held) whenever capturing another bit would overflow the pack/staging storage.
  - No bit is lost or duplicated under any m_ready pattern.
- m_last = 1 only with word 2^A_WIDTH/OUT_WIDTH - 1.
- ram_rs is held constant for the whole frame, including stall cycles.

Test Plan:
- Bank 0 preloaded with bit = (a%3==0), A_WIDTH=8, OUT_WIDTH=8, m_ready=1, start bank=0 -> expected responses:
  - 32 words, word0=0x49, word1=0x92, word2=0x24.
  - First m_valid 8 cycles after start, then every 8 cycles.
  - m_last only on word 31; done pulse one cycle after its handshake.
- Bank 0 all 0, bank 1 all 1, start bank=1 -> all 32 words 0xFF, ram_rs=1 throughout, ram_we=0 always.
- Same pattern as test 1, m_ready held 0 for 20 cycles after first m_valid -> m_data held 0x49 stable; ram_cs drops once staging is full; after release all 32 words arrive in order with correct values.
- m_ready toggling every cycle plus a start pulse while busy -> the second start is ignored; exactly 32 correct words and one done.
- Assert rst_n=0 during word 10 -> m_valid, busy, ram_cs go 0 immediately with no done. After release, start bank=0 -> output restarts at word0=0x49.
- OUT_WIDTH=1 -> 256 words, each equal to the RAM bit, first m_valid 1 cycle after start, m_last on word 255.
